// File: rtl/cy_status_pkg.sv
// Shared constants and helpers for the sticky status register.
package cy_status_pkg;

    localparam int STATUS_WIDTH = 8;
    localparam logic [STATUS_WIDTH-1:0] STATUS_RST = 8'h00;

    // Bit i is set when i < num_inputs, so only live status lines are kept.
    function automatic logic [STATUS_WIDTH-1:0] valid_mask(input int num_inputs);
        logic [STATUS_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < STATUS_WIDTH; i++) begin
            if (i < num_inputs) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/cy_status_reg_sticky_bit.sv
// One status bit: edge-detect history flop, sticky/transparent select, and the
// register flop.
module cy_status_bit #(
    parameter bit Sticky  = 1'b0,
    parameter bit EdgeSet = 1'b0,
    parameter bit Live    = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic status_in,
    input  logic clr,
    output logic reg_q,
    output logic reg_next
);

    logic prev_q;
    logic rise;
    logic set;

    // Set dominates clear so an event arriving during a read is never dropped.
    always_comb begin
        rise     = status_in & ~prev_q;
        set      = EdgeSet ? rise : status_in;
        reg_next = 1'b0;
        if (Live) begin
            if (Sticky) begin
                reg_next = (reg_q & ~clr) | set;
            end else begin
                reg_next = status_in;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b0;
            reg_q  <= 1'b0;
        end else begin
            prev_q <= status_in;
            reg_q  <= reg_next;
        end
    end

endmodule

// File: rtl/cy_status_reg_sticky.sv
// Hardware-to-CPU status register with sticky/transparent bits, clear-on-read
// and a masked level interrupt. Define CY_STATUS_SYNC_EN to add an input synchronizer.
module cy_status_reg_sticky
    import cy_status_pkg::*;
#(
    parameter int                      NumInputs  = 8,
    parameter logic [STATUS_WIDTH-1:0] StickyMask = 8'h00,
    parameter logic [STATUS_WIDTH-1:0] EdgeMask   = 8'h00,
    parameter logic [STATUS_WIDTH-1:0] IntrMask   = 8'h00
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [STATUS_WIDTH-1:0] status_in,
    input  logic                    rd_en,
    output logic [STATUS_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    irq
);

    localparam logic [STATUS_WIDTH-1:0] LIVE = valid_mask(NumInputs);

    logic [STATUS_WIDTH-1:0] status_s;
    logic [STATUS_WIDTH-1:0] reg_q;
    logic [STATUS_WIDTH-1:0] reg_next;

`ifdef CY_STATUS_SYNC_EN
    logic [STATUS_WIDTH-1:0] sync1_q;
    logic [STATUS_WIDTH-1:0] sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= STATUS_RST;
            sync2_q <= STATUS_RST;
        end else begin
            sync1_q <= status_in;
            sync2_q <= sync1_q;
        end
    end

    assign status_s = sync2_q;
`else
    assign status_s = status_in;
`endif

    for (genvar i = 0; i < STATUS_WIDTH; i++) begin : g_bit
        cy_status_bit #(
            .Sticky  (StickyMask[i]),
            .EdgeSet (EdgeMask[i]),
            .Live    (LIVE[i])
        ) u_bit (
            .clock     (clock),
            .reset     (reset),
            .status_in (status_s[i]),
            .clr       (rd_en),
            .reg_q     (reg_q[i]),
            .reg_next  (reg_next[i])
        );
    end

    // rd_data captures the pre-clear value; irq follows reg_next so it moves with reg_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data  <= STATUS_RST;
            rd_valid <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= reg_q & LIVE;
            end
            irq <= |(reg_next & IntrMask & LIVE);
        end
    end

endmodule
